shift_s_to_p_rx: RTL

Serial-to-parallel receiver. It is the far end of the 8-bit parallel-to-serial shifter link: it collects a framed, MSB-first serial bit stream into a WIDTH-bit word. It then presents the word on a valid/ready holding register to the microprocessor datapath. A bit counter frames each word, and the block flags overrun when the consumer stalls.

---
 rtl/shift_s_to_p_rx.sv | 85 ++++++++
 1 files changed

// File: rtl/shift_s_to_p_rx.sv
// Serial-to-parallel receiver: frames an sValid bit stream into WIDTH-bit
// words and hands them off through a valid/ready holding register.
module shift_s_to_p_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       Clock,
    input  logic                       rst,
    input  logic                       sIn,
    input  logic                       sValid,
    input  logic                       frame_start,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun
);

    localparam int CW = $clog2(WIDTH+1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    logic             take;
    logic             done;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] next_sr;
    logic [CW-1:0]    next_cnt;

    // frame_start always restarts from an empty register, discarding any partial word
    always_comb begin
        take     = sValid && (frame_start || (state == SHIFT));
        base     = frame_start ? '0 : sr;
        next_cnt = frame_start ? CW'(1) : cnt + CW'(1);
        if (MSB_FIRST)
            next_sr = {base[WIDTH-2:0], sIn};
        else
            next_sr = {sIn, base[WIDTH-1:1]};
        done = take && (next_cnt == CW'(WIDTH));
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (take) begin
            sr <= next_sr;
            if (done) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= SHIFT;
                cnt   <= next_cnt;
            end
        end
    end

    // A completed word may replace the held one only if it is being consumed
    always_ff @(posedge Clock) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!data_valid || data_ready) begin
                data_out   <= next_sr;
                data_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

    assign busy      = (state == SHIFT);
    assign bit_count = cnt;

endmodule
